// File: rtl/inst_queue.sv
// inst_queue: dual-issue instruction queue splitting fetch packages into single-instruction FIFO entries.
// Optional IQ_BYPASS_EN: zero-latency pass-through of a package into an empty queue. Rev 1.0
`default_nettype none

module inst_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic [127:0]     pkg_i,
   input  logic             pkg_valid_i,
   output logic             stall_o,
   output logic             out0_valid_o,
   output logic [31:0]      out0_pc_o,
   output logic [31:0]      out0_inst_o,
   output logic             out0_br_o,
   output logic             out0_pt_o,
   output logic             out1_valid_o,
   output logic [31:0]      out1_pc_o,
   output logic [31:0]      out1_inst_o,
   output logic             out1_br_o,
   output logic             out1_pt_o,
   input  logic [1:0]       deq_cnt_i,
   output logic [PTR_W:0]   count_o
);

   // Entry layout: [65:34] pc, [33:2] inst, [1] br, [0] pt
   logic [65:0]      mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head1;
   logic [PTR_W:0]   count;

   logic [65:0] ent_a, ent_b, first_ent, slot0, slot1;
   logic        pv1, pv2, accept, valid0, valid1;
   logic [1:0]  enq_n, deq_sat, avail, eff_deq;
   logic        unused_bits;

   assign unused_bits = ^pkg_i[25:0];

   assign pv1       = pkg_i[31];
   assign pv2       = pkg_i[30];
   assign ent_a     = {pkg_i[127:96], pkg_i[95:64], pkg_i[29], pkg_i[28]};
   assign ent_b     = {pkg_i[127:96] + 32'd4, pkg_i[63:32], pkg_i[27], pkg_i[26]};
   assign first_ent = pv1 ? ent_a : ent_b;

   // Stall leaves room for a full two-entry package whatever decode consumes.
   assign stall_o = count > (PTR_W+1)'(DEPTH - 2);
   assign accept  = pkg_valid_i && !stall_o && !flush_i;
   assign enq_n   = accept ? ({1'b0, pv1} + {1'b0, pv2}) : 2'd0;
   assign deq_sat = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
   assign head1   = head + PTR_W'(1);
   assign count_o = count;

   always_comb begin
      slot0  = mem[head];
      slot1  = mem[head1];
      valid0 = (count != '0);
      valid1 = (count > (PTR_W+1)'(1));
`ifdef IQ_BYPASS_EN
      // Bypassed entries are still written, but head skips any that decode consumes now.
      if (count == '0 && enq_n != 2'd0) begin
         slot0  = first_ent;
         slot1  = ent_b;
         valid0 = 1'b1;
         valid1 = (enq_n == 2'd2);
      end
`endif
      avail   = {1'b0, valid0} + {1'b0, valid1};
      eff_deq = (deq_sat > avail) ? avail : deq_sat;
   end

   assign out0_valid_o = valid0;
   assign out0_pc_o    = valid0 ? slot0[65:34] : 32'd0;
   assign out0_inst_o  = valid0 ? slot0[33:2]  : 32'd0;
   assign out0_br_o    = valid0 & slot0[1];
   assign out0_pt_o    = valid0 & slot0[0];
   assign out1_valid_o = valid1;
   assign out1_pc_o    = valid1 ? slot1[65:34] : 32'd0;
   assign out1_inst_o  = valid1 ? slot1[33:2]  : 32'd0;
   assign out1_br_o    = valid1 & slot1[1];
   assign out1_pt_o    = valid1 & slot1[0];

   always_ff @(posedge clk) begin
      if (!rst && enq_n != 2'd0) begin
         mem[tail] <= first_ent;
      end
      if (!rst && enq_n == 2'd2) begin
         mem[tail + PTR_W'(1)] <= ent_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(eff_deq);
         tail  <= tail + PTR_W'(enq_n);
         count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(eff_deq);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vector table plus multi-cycle sequences for inst_queue (DEPTH=16).
`default_nettype none

module tb_inst_queue;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush_i;
   logic [127:0] pkg_i;
   logic         pkg_valid_i;
   logic         stall_o;
   logic         out0_valid_o, out0_br_o, out0_pt_o;
   logic [31:0]  out0_pc_o, out0_inst_o;
   logic         out1_valid_o, out1_br_o, out1_pt_o;
   logic [31:0]  out1_pc_o, out1_inst_o;
   logic [1:0]   deq_cnt_i;
   logic [4:0]   count_o;

   int nvec = 0;
   int nfail = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .pkg_i(pkg_i), .pkg_valid_i(pkg_valid_i),
      .stall_o(stall_o),
      .out0_valid_o(out0_valid_o), .out0_pc_o(out0_pc_o), .out0_inst_o(out0_inst_o),
      .out0_br_o(out0_br_o), .out0_pt_o(out0_pt_o),
      .out1_valid_o(out1_valid_o), .out1_pc_o(out1_pc_o), .out1_inst_o(out1_inst_o),
      .out1_br_o(out1_br_o), .out1_pt_o(out1_pt_o),
      .deq_cnt_i(deq_cnt_i), .count_o(count_o)
   );

   typedef struct {
      logic        fl, pv;
      logic [31:0] pc, i1, i2;
      logic        v1, v2, br1, pt1, br2, pt2;
      logic [1:0]  dq;
      logic [4:0]  ecnt;
      logic        ev0, ev1;
      logic [31:0] epc0, einst0;
      logic        ebr0, ept0;
      logic [31:0] epc1, einst1;
   } vec_t;

   vec_t vec [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      flush_i     = 1'b0;
      pkg_valid_i = 1'b0;
      pkg_i       = '0;
      deq_cnt_i   = 2'd0;
   endtask

   task automatic drive(input logic fl, input logic pv, input logic [31:0] pc, input logic [31:0] i1,
                        input logic [31:0] i2, input logic a, input logic b, input logic br1,
                        input logic pt1, input logic br2, input logic pt2, input logic [1:0] dq);
      flush_i     = fl;
      pkg_valid_i = pv;
      pkg_i       = {pc, i1, i2, a, b, br1, pt1, br2, pt2, 26'd0};
      deq_cnt_i   = dq;
   endtask

   // One cycle against the queue model; outputs checked after the edge with inputs idle.
   task automatic step(input logic fl, input logic pv, input logic [31:0] pc,
                       input logic a, input logic b, input logic [1:0] dq);
      int n;
      int d;
      logic st;
      n  = q.size();
      st = (16 - n) < 2;
      drive(fl, pv, pc, ~pc, ~(pc + 32'd4), a, b, 1'b0, 1'b0, 1'b0, 1'b0, dq);
      @(posedge clk);
      #1;
      idle();
      if (fl) begin
         q.delete();
      end else begin
         d = (dq == 2'd3) ? 2 : int'(dq);
         if (d > n) d = n;
         repeat (d) void'(q.pop_front());
         if (pv && !st) begin
            if (a) q.push_back(pc);
            if (b) q.push_back(pc + 32'd4);
         end
      end
      nvec++;
      chk("seq_count", 32'(count_o), 32'(q.size()));
      chk("seq_stall", 32'(stall_o), 32'((16 - q.size()) < 2));
      chk("seq_v0", 32'(out0_valid_o), 32'(q.size() >= 1));
      chk("seq_v1", 32'(out1_valid_o), 32'(q.size() >= 2));
      chk("seq_pc0", out0_pc_o, (q.size() >= 1) ? q[0] : 32'd0);
      chk("seq_pc1", out1_pc_o, (q.size() >= 2) ? q[1] : 32'd0);
   endtask

   initial begin
      vec[0]  = '{0,1,32'h80000000,32'h02800421,32'h02800842,1,1,0,0,0,0,2'd0,
                  5'd2,1,1,32'h80000000,32'h02800421,0,0,32'h80000004,32'h02800842};
      vec[1]  = '{0,0,0,0,0,0,0,0,0,0,0,2'd2, 5'd0,0,0,0,0,0,0,0,0};
      vec[2]  = '{0,1,32'h1000,32'hAAAA0001,32'hBBBB0002,1,0,1,1,0,0,2'd0,
                  5'd1,1,0,32'h1000,32'hAAAA0001,1,1,0,0};
      vec[3]  = '{0,0,0,0,0,0,0,0,0,0,0,2'd2, 5'd0,0,0,0,0,0,0,0,0};
      vec[4]  = '{0,1,32'h2000,32'h11,32'h22,0,1,1,1,1,0,2'd0,
                  5'd1,1,0,32'h2004,32'h22,1,0,0,0};
      vec[5]  = '{0,1,32'h3000,32'h33,32'h44,1,1,0,0,0,1,2'd1,
                  5'd2,1,1,32'h3000,32'h33,0,0,32'h3004,32'h44};
      vec[6]  = '{0,0,0,0,0,0,0,0,0,0,0,2'd3, 5'd0,0,0,0,0,0,0,0,0};
      vec[7]  = '{0,1,32'h4000,32'h55,32'h66,1,1,0,0,0,0,2'd0,
                  5'd2,1,1,32'h4000,32'h55,0,0,32'h4004,32'h66};
      vec[8]  = '{1,1,32'h5000,32'h77,32'h88,1,1,0,0,0,0,2'd0, 5'd0,0,0,0,0,0,0,0,0};
      vec[9]  = '{0,1,32'h7000,32'h1,32'h2,0,0,1,1,1,1,2'd0, 5'd0,0,0,0,0,0,0,0,0};
      vec[10] = '{0,1,32'h6000,32'h99,32'hAA,1,1,0,0,0,0,2'd0,
                  5'd2,1,1,32'h6000,32'h99,0,0,32'h6004,32'hAA};
      vec[11] = '{0,0,0,0,0,0,0,0,0,0,0,2'd1, 5'd1,1,0,32'h6004,32'hAA,0,0,0,0};

      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      nvec++;
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_v0", 32'(out0_valid_o), 32'd0);
      chk("rst_v1", 32'(out1_valid_o), 32'd0);
      chk("rst_pc0", out0_pc_o, 32'd0);
      chk("rst_inst1", out1_inst_o, 32'd0);

      for (int i = 0; i < 12; i++) begin
         drive(vec[i].fl, vec[i].pv, vec[i].pc, vec[i].i1, vec[i].i2, vec[i].v1, vec[i].v2,
               vec[i].br1, vec[i].pt1, vec[i].br2, vec[i].pt2, vec[i].dq);
         @(posedge clk);
         #1;
         idle();
         nvec++;
         chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vec[i].ecnt));
         chk($sformatf("v%0d_v0", i), 32'(out0_valid_o), 32'(vec[i].ev0));
         chk($sformatf("v%0d_v1", i), 32'(out1_valid_o), 32'(vec[i].ev1));
         chk($sformatf("v%0d_pc0", i), out0_pc_o, vec[i].epc0);
         chk($sformatf("v%0d_inst0", i), out0_inst_o, vec[i].einst0);
         chk($sformatf("v%0d_br0", i), 32'(out0_br_o), 32'(vec[i].ebr0));
         chk($sformatf("v%0d_pt0", i), 32'(out0_pt_o), 32'(vec[i].ept0));
         chk($sformatf("v%0d_pc1", i), out1_pc_o, vec[i].epc1);
         chk($sformatf("v%0d_inst1", i), out1_inst_o, vec[i].einst1);
         chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'd0);
      end

      // Fill to 15 with no dequeue, hold a stalled package, then release it.
      step(1, 0, 0, 0, 0, 2'd0);
      step(0, 1, 32'h9000, 1, 0, 2'd0);
      for (int k = 0; k < 7; k++) step(0, 1, 32'h9004 + 32'(8 * k), 1, 1, 2'd0);
      for (int k = 0; k < 3; k++) step(0, 1, 32'h903C, 1, 1, 2'd0);
      step(0, 1, 32'h903C, 1, 1, 2'd2);
      step(0, 1, 32'h903C, 1, 1, 2'd2);
      for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 2'd2);

      // Steady state: two in, two out per cycle across pointer wrap.
      step(0, 1, 32'hA000, 1, 1, 2'd0);
      for (int k = 1; k <= 20; k++) step(0, 1, 32'hA000 + 32'(8 * k), 1, 1, 2'd2);
      step(0, 0, 0, 0, 0, 2'd2);

      // Flush at occupancy 6 drops the same-cycle package.
      for (int k = 0; k < 3; k++) step(0, 1, 32'hC000 + 32'(8 * k), 1, 1, 2'd0);
      step(1, 1, 32'hD000, 1, 1, 2'd2);

      // Over-dequeue from one entry clamps to zero.
      step(0, 1, 32'hE000, 1, 0, 2'd0);
      step(0, 0, 0, 0, 0, 2'd2);

      // Reset mid-operation.
      step(0, 1, 32'hF000, 1, 1, 2'd0);
      step(0, 1, 32'hF008, 1, 1, 2'd0);
      drive(0, 1, 32'hF010, 32'h1, 32'h2, 1, 1, 1, 1, 1, 1, 2'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      q.delete();
      nvec++;
      chk("midrst_count", 32'(count_o), 32'd0);
      chk("midrst_v0", 32'(out0_valid_o), 32'd0);
      chk("midrst_pc0", out0_pc_o, 32'd0);
      chk("midrst_stall", 32'(stall_o), 32'd0);

`ifdef IQ_BYPASS_EN
      drive(0, 1, 32'hB000, 32'h12, 32'h34, 1, 1, 0, 0, 0, 0, 2'd2);
      #1;
      nvec++;
      chk("byp_v0", 32'(out0_valid_o), 32'd1);
      chk("byp_pc0", out0_pc_o, 32'hB000);
      chk("byp_inst0", out0_inst_o, 32'h12);
      chk("byp_v1", 32'(out1_valid_o), 32'd1);
      chk("byp_pc1", out1_pc_o, 32'hB004);
      @(posedge clk);
      #1;
      idle();
      nvec++;
      chk("byp_count", 32'(count_o), 32'd0);
      chk("byp_after_v0", 32'(out0_valid_o), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

`default_nettype wire
